// File: rtl/fc_argmax_ctrl.sv
// Sequencer and argmax classifier around the FC dot-product stage. It runs one FC pass per
// class, keeps the running maximum score, and reports the winner, a reject flag and a watchdog error.
module fc_argmax_ctrl #(
   parameter int NUM_CLASS = 5,
   parameter int IDX_W     = 3,
   parameter int TIMEOUT   = 15
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic signed [31:0] i_threshold,
   output logic               o_fc_start,
   output logic [IDX_W-1:0]   o_class_sel,
   input  logic signed [31:0] i_fc_output,
   input  logic               i_fc_finished,
   output logic               o_busy,
   output logic               o_valid,
   output logic [IDX_W-1:0]   o_class,
   output logic signed [31:0] o_score,
   output logic               o_reject,
   output logic               o_error
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASS - 1);
   localparam logic [7:0]       WD_LAST  = 8'(TIMEOUT - 1);

   logic [1:0]         state_q, state_d;
   logic [IDX_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         wd_q, wd_d;
   logic signed [31:0] thr_q, thr_d;
   logic signed [31:0] max_q, max_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               first_q, first_d;
   logic               err_q, err_d;
   logic               valid_q, valid_d;
   logic [IDX_W-1:0]   class_q, class_d;
   logic signed [31:0] score_q, score_d;
   logic               reject_q, reject_d;
   logic               error_q, error_d;
   logic               advance;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
      state_d  = state_q;
      cnt_d    = cnt_q;
      wd_d     = wd_q;
      thr_d    = thr_q;
      max_d    = max_q;
      idx_d    = idx_q;
      first_d  = first_q;
      err_d    = err_q;
      valid_d  = 1'b0;
      class_d  = class_q;
      score_d  = score_q;
      reject_d = reject_q;
      error_d  = error_q;
      advance  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               thr_d   = i_threshold;
               cnt_d   = '0;
               max_d   = '0;
               idx_d   = '0;
               first_d = 1'b1;
               err_d   = 1'b0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            wd_d    = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (i_fc_finished) begin
               if (first_q || (i_fc_output > max_q)) begin
                  max_d = i_fc_output;
                  idx_d = cnt_q;
               end
               first_d = 1'b0;
               advance = 1'b1;
            end else if (wd_q == WD_LAST) begin
               // Stalled FC stage: skip this class without touching the running maximum.
               err_d   = 1'b1;
               advance = 1'b1;
            end else begin
               wd_d = wd_q + 8'd1;
            end
            if (advance) begin
               if (cnt_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = S_ISSUE;
               end
            end
         end
         default: begin
            valid_d = 1'b1;
            error_d = err_q;
            if (first_q) begin
               // No class ever produced a score.
               class_d  = '0;
               score_d  = '0;
               reject_d = 1'b1;
            end else begin
               class_d  = idx_q;
               score_d  = max_q;
               reject_d = (max_q < thr_q);
            end
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         wd_q     <= '0;
         thr_q    <= '0;
         max_q    <= '0;
         idx_q    <= '0;
         first_q  <= 1'b0;
         err_q    <= 1'b0;
         valid_q  <= 1'b0;
         class_q  <= '0;
         score_q  <= '0;
         reject_q <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wd_q     <= wd_d;
         thr_q    <= thr_d;
         max_q    <= max_d;
         idx_q    <= idx_d;
         first_q  <= first_d;
         err_q    <= err_d;
         valid_q  <= valid_d;
         class_q  <= class_d;
         score_q  <= score_d;
         reject_q <= reject_d;
         error_q  <= error_d;
      end
   end

   assign o_fc_start  = (state_q == S_ISSUE);
   assign o_class_sel = cnt_q;
   assign o_busy      = (state_q != S_IDLE) || valid_q;
   assign o_valid     = valid_q;
   assign o_class     = class_q;
   assign o_score     = score_q;
   assign o_reject    = reject_q;
   assign o_error     = error_q;

endmodule

// File: tb/tb_fc_argmax_ctrl.sv
// Scoreboard bench for fc_argmax_ctrl: a behavioural FC stage with L=2 and per-class hang,
// directed runs push hand-computed results, and a monitor checks every o_valid pulse.
module tb_fc_argmax_ctrl;

   localparam int NUM_CLASS = 5;
   localparam int IDX_W     = 3;
   localparam int TIMEOUT   = 15;
   localparam int FC_LAT    = 2;

   typedef struct {
      logic [IDX_W-1:0]   cls;
      logic signed [31:0] score;
      logic               rej;
      logic               err;
      int                 cyc;
   } exp_t;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic signed [31:0] threshold;
   logic               fc_start;
   logic [IDX_W-1:0]   class_sel;
   logic signed [31:0] fc_output;
   logic               fc_finished;
   logic               busy;
   logic               valid;
   logic [IDX_W-1:0]   cls;
   logic signed [31:0] score;
   logic               reject;
   logic               error;

   int                 cyc;
   int                 n_vec;
   int                 n_err;
   exp_t               exp_q[$];
   exp_t               e;
   int                 sel_log[$];
   logic signed [31:0] score_tbl[NUM_CLASS];
   logic [NUM_CLASS-1:0] hang_mask;

   fc_argmax_ctrl #(
      .NUM_CLASS(NUM_CLASS),
      .IDX_W    (IDX_W),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (start),
      .i_threshold  (threshold),
      .o_fc_start   (fc_start),
      .o_class_sel  (class_sel),
      .i_fc_output  (fc_output),
      .i_fc_finished(fc_finished),
      .o_busy       (busy),
      .o_valid      (valid),
      .o_class      (cls),
      .o_score      (score),
      .o_reject     (reject),
      .o_error      (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, $signed(act), act,
                  $signed(exp), exp);
      end
   endtask

   // Behavioural FC stage: answers FC_LAT cycles after each start pulse unless that class hangs.
   initial begin
      int sel;
      fc_finished = 1'b0;
      fc_output   = '0;
      forever begin
         @(negedge clk);
         if (fc_start) begin
            sel = int'(class_sel);
            sel_log.push_back(sel);
            if (!hang_mask[sel]) begin
               repeat (FC_LAT) @(posedge clk);
               #1;
               fc_finished = 1'b1;
               fc_output   = score_tbl[sel];
               @(negedge clk);
               if (rst_n) check("class_sel_hold", 32'(class_sel), 32'(sel));
               @(posedge clk);
               #1;
               fc_finished = 1'b0;
               fc_output   = 32'hDEAD_BEEF;
            end
         end
      end
   end

   // Monitor: every result pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (valid) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_valid: o_valid=1 at cycle %0d with no run outstanding, expected 0", cyc);
         end else begin
            e = exp_q.pop_front();
            check("o_class", 32'(cls), 32'(e.cls));
            check("o_score", score, e.score);
            check("o_reject", 32'(reject), 32'(e.rej));
            check("o_error", 32'(error), 32'(e.err));
            check("latency_cycle", 32'(cyc), 32'(e.cyc));
            check("busy_at_valid", 32'(busy), 32'd1);
         end
      end
   end

   task automatic set_scores(input int a, input int b, input int c, input int d, input int f,
                             input logic [NUM_CLASS-1:0] hang);
      score_tbl[0] = a;
      score_tbl[1] = b;
      score_tbl[2] = c;
      score_tbl[3] = d;
      score_tbl[4] = f;
      hang_mask    = hang;
   endtask

   // Pulses i_start for one cycle; optionally queues the expected result and its arrival cycle.
   task automatic launch(input logic signed [31:0] thr, input logic push,
                         input int exp_cls, input int exp_score, input logic exp_rej,
                         input logic exp_err, input int lat, output int c0);
      exp_t x;
      @(posedge clk);
      #1;
      start     = 1'b1;
      threshold = thr;
      c0        = cyc;
      if (push) begin
         x.cls   = IDX_W'(exp_cls);
         x.score = exp_score;
         x.rej   = exp_rej;
         x.err   = exp_err;
         x.cyc   = c0 + lat;
         exp_q.push_back(x);
      end
      @(posedge clk);
      #1;
      start     = 1'b0;
      threshold = 32'sd12345;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      check("run_completed", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      check("busy_after_valid", 32'(busy), 32'd0);
      repeat (25) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 32'(valid), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_fc_start"}, 32'(fc_start), 32'd0);
      check({tag, "_class_sel"}, 32'(class_sel), 32'd0);
      check({tag, "_class"}, 32'(cls), 32'd0);
      check({tag, "_score"}, score, 32'd0);
      check({tag, "_reject"}, 32'(reject), 32'd0);
      check({tag, "_error"}, 32'(error), 32'd0);
   endtask

   initial begin
      int c0;
      cyc       = 0;
      n_vec     = 0;
      n_err     = 0;
      start     = 1'b0;
      threshold = '0;
      rst_n     = 1'b0;
      set_scores(0, 0, 0, 0, 0, 5'b00000);
      #3;
      check_reset_outputs("reset");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Basic argmax, plus the start-pulse/row-select sequence.
      set_scores(10, -3, 42, 41, 7, 5'b00000);
      sel_log.delete();
      launch(0, 1'b1, 2, 42, 1'b0, 1'b0, 17, c0);
      wait_done();
      check("fc_start_count", 32'(sel_log.size()), 32'd5);
      for (int i = 0; i < NUM_CLASS && i < sel_log.size(); i++)
         check("fc_start_sel", 32'(sel_log[i]), 32'(i));

      // Tie among negatives: lower index wins.
      set_scores(-100, -5, -7, -5, -200, 5'b00000);
      launch(-1000, 1'b1, 1, -5, 1'b0, 1'b0, 17, c0);
      wait_done();

      // Winner below threshold.
      set_scores(10, -3, 42, 41, 7, 5'b00000);
      launch(50, 1'b1, 2, 42, 1'b1, 1'b0, 17, c0);
      wait_done();

      // Class 3 stalls: watchdog skips it.
      set_scores(1, 2, 3, 100, 9, 5'b01000);
      launch(0, 1'b1, 4, 9, 1'b0, 1'b1, 30, c0);
      wait_done();

      // Busy protection: extra starts at cycles 3 and 10 of the run are ignored.
      set_scores(5, 6, 7, 8, 4, 5'b00000);
      launch(0, 1'b1, 3, 8, 1'b0, 1'b0, 17, c0);
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      start = 1'b1;
      check("busy_mid_run", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done();

      // Reset during the class 2 wait aborts the run with no result.
      set_scores(1, 2, 3, 4, 5, 5'b00000);
      launch(0, 1'b0, 0, 0, 1'b0, 1'b0, 0, c0);
      repeat (7) @(posedge clk);
      #1;
      check("class_sel_before_reset", 32'(class_sel), 32'd2);
      check("busy_before_reset", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrun_reset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("no_valid_after_abort", 32'(exp_q.size()), 32'd0);

      // Normal run after reset; score equal to threshold is accepted.
      set_scores(3, 3, 3, 3, 3, 5'b00000);
      launch(3, 1'b1, 0, 3, 1'b0, 1'b0, 17, c0);
      wait_done();

      // Every class stalls.
      set_scores(1, 2, 3, 4, 5, 5'b11111);
      launch(0, 1'b1, 0, 0, 1'b1, 1'b1, 82, c0);
      wait_done();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
      $fatal(1, "bench timeout");
   end

endmodule
